// File: rtl/program_counter_fetch.sv
// Fetch-stage PC unit: 64-bit PC, next-PC selection (PC+4 / B / CBZ / CBNZ / BR) and BOOT/RUN/HALT run control.
// Optional: define PC_ALIGN_CHECK_EN to add a sticky 'fault' output that halts on a misaligned BR target.
module program_counter_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [63:0] IM_BYTES = 64'd128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        br_uncond,
    input  logic        br_cbz,
    input  logic        br_cbnz,
    input  logic        br_reg,
    input  logic        zero,
    input  logic [25:0] imm26,
    input  logic [18:0] imm19,
    input  logic [63:0] reg_target,
    output logic [61:0] direccion,
    output logic [63:0] pc,
    output logic [63:0] pc_plus4,
    output logic        fetch_valid,
    output logic        taken,
`ifdef PC_ALIGN_CHECK_EN
    output logic        fault,
`endif
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t      state_reg, state_next;
    logic [63:0] pc_reg, pc_next;
    logic [63:0] off26, off19, reg_dest, sel_pc;
    logic        cond_taken, any_branch, run_go, misaligned, out_of_range;
`ifdef PC_ALIGN_CHECK_EN
    logic        fault_reg, fault_next;
`endif

    // Branch offsets are word counts; append two zero bits after sign extension.
    assign off26 = {{36{imm26[25]}}, imm26, 2'b00};
    assign off19 = {{43{imm19[18]}}, imm19, 2'b00};

`ifdef PC_ALIGN_CHECK_EN
    assign reg_dest = reg_target;
`else
    assign reg_dest = reg_target & ~64'h3;
`endif

    assign cond_taken = (br_cbz & zero) | (br_cbnz & ~zero);
    assign any_branch = br_reg | br_uncond | cond_taken;
    assign run_go     = (state_reg == ST_RUN) && !reset && !stall && !halt_req;

    always_comb begin
        sel_pc = pc_reg + 64'd4;
        if (br_reg)
            sel_pc = reg_dest;
        else if (br_uncond)
            sel_pc = pc_reg + off26;
        else if (cond_taken)
            sel_pc = pc_reg + off19;
    end

`ifdef PC_ALIGN_CHECK_EN
    assign misaligned = (sel_pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif
    assign out_of_range = (sel_pc >= IM_BYTES);

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
`ifdef PC_ALIGN_CHECK_EN
        fault_next = fault_reg;
`endif
        case (state_reg)
            ST_BOOT: begin
                if (!stall)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_next = ST_HALT;
                end else if (!stall) begin
                    // Out-of-bounds or misaligned targets stop the core with pc on the last executed instruction.
                    if (misaligned) begin
                        state_next = ST_HALT;
`ifdef PC_ALIGN_CHECK_EN
                        fault_next = 1'b1;
`endif
                    end else if (out_of_range) begin
                        state_next = ST_HALT;
                    end else begin
                        pc_next = sel_pc;
                    end
                end
            end
            default: begin
                state_next = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_BOOT;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset)
            fault_reg <= 1'b0;
        else
            fault_reg <= fault_next;
    end
    assign fault = fault_reg;
`endif

    assign pc          = pc_reg;
    assign direccion   = pc_reg[63:2];
    assign pc_plus4    = pc_reg + 64'd4;
    assign fetch_valid = (state_reg == ST_RUN) && !reset && !stall;
    assign taken       = run_go && any_branch;
    assign halted      = (state_reg == ST_HALT);

endmodule

// File: tb/tb_program_counter_fetch.sv
// Self-checking bench for program_counter_fetch: directed scenarios then randomized steps against a reference model.
module tb_program_counter_fetch;

    logic        clk = 1'b0;
    logic        reset, stall, halt_req, br_uncond, br_cbz, br_cbnz, br_reg, zero;
    logic [25:0] imm26;
    logic [18:0] imm19;
    logic [63:0] reg_target;
    logic [61:0] direccion;
    logic [63:0] pc, pc_plus4;
    logic        fetch_valid, taken, halted;
`ifdef PC_ALIGN_CHECK_EN
    logic        fault;
`endif

    always #5 clk = ~clk;

    program_counter_fetch #(.RESET_PC(64'h0), .IM_BYTES(64'd128)) dut (
        .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req),
        .br_uncond(br_uncond), .br_cbz(br_cbz), .br_cbnz(br_cbnz), .br_reg(br_reg),
        .zero(zero), .imm26(imm26), .imm19(imm19), .reg_target(reg_target),
        .direccion(direccion), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid), .taken(taken),
`ifdef PC_ALIGN_CHECK_EN
        .fault(fault),
`endif
        .halted(halted)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: where the program is and whether it has started/stopped.
    logic [63:0] m_pc = 64'h0;
    bit          m_boot = 1'b1;
    bit          m_halt = 1'b0;
    bit          m_fault = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_redirect();
        return br_reg || br_uncond || (br_cbz && zero) || (br_cbnz && !zero);
    endfunction

    // Destination of the current instruction computed with signed arithmetic on the offsets.
    function automatic logic [63:0] m_dest();
        longint off;
        if (br_reg) begin
`ifdef PC_ALIGN_CHECK_EN
            return reg_target;
`else
            return {reg_target[63:2], 2'b00};
`endif
        end
        if (br_uncond) begin
            off = longint'($signed(imm26));
            return m_pc + 64'(off * 4);
        end
        if ((br_cbz && zero) || (br_cbnz && !zero)) begin
            off = longint'($signed(imm19));
            return m_pc + 64'(off * 4);
        end
        return m_pc + 64'd4;
    endfunction

    task automatic step(input string tag, input logic rs, st, hr, bu, bz, bnz, brg, z,
                        input logic [25:0] i26, input logic [18:0] i19, input logic [63:0] rt,
                        output logic fv_o, output logic tk_o);
        logic [63:0] dest;
        bit          running, exp_fv, exp_tk;
        @(negedge clk);
        reset = rs; stall = st; halt_req = hr; br_uncond = bu; br_cbz = bz;
        br_cbnz = bnz; br_reg = brg; zero = z; imm26 = i26; imm19 = i19; reg_target = rt;
        #1;
        running = !m_boot && !m_halt;
        exp_fv  = running && !rs && !st;
        exp_tk  = exp_fv && !hr && m_redirect();
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".direccion"}, 64'(direccion), m_pc / 4);
        chk({tag, ".pc_plus4"}, pc_plus4, m_pc + 64'd4);
        chk({tag, ".fetch_valid"}, 64'(fetch_valid), 64'(exp_fv));
        chk({tag, ".taken"}, 64'(taken), 64'(exp_tk));
        chk({tag, ".halted"}, 64'(halted), 64'(m_halt));
`ifdef PC_ALIGN_CHECK_EN
        chk({tag, ".fault"}, 64'(fault), 64'(m_fault));
`endif
        fv_o = fetch_valid;
        tk_o = taken;
        $display("step %-10s rst=%0d st=%0d hr=%0d b=%0d cbz=%0d cbnz=%0d br=%0d z=%0d pc=%0h fv=%0d tk=%0d halted=%0d",
                 tag, rs, st, hr, bu, bz, bnz, brg, z, pc, fetch_valid, taken, halted);
        dest = m_dest();
        @(posedge clk);
        #1;
        if (rs) begin
            m_pc = 64'h0; m_boot = 1'b1; m_halt = 1'b0; m_fault = 1'b0;
        end else if (m_halt) begin
            // frozen until reset
        end else if (m_boot) begin
            if (!st) m_boot = 1'b0;
        end else if (hr) begin
            m_halt = 1'b1;
        end else if (!st) begin
`ifdef PC_ALIGN_CHECK_EN
            if (dest % 4 != 0) begin
                m_halt = 1'b1; m_fault = 1'b1;
            end else
`endif
            if (dest >= 64'd128) m_halt = 1'b1;
            else m_pc = dest;
        end
    endtask

    logic fv, tk;

    initial begin
        reset = 1'b1; stall = 1'b0; halt_req = 1'b0; br_uncond = 1'b0; br_cbz = 1'b0;
        br_cbnz = 1'b0; br_reg = 1'b0; zero = 1'b0; imm26 = '0; imm19 = '0; reg_target = '0;

        // Power-on reset, then one BOOT cycle with no fetch.
        step("reset", 1,0,0,0,0,0,0,0, 26'h0, 19'h0, 64'h0, fv, tk);
        chk("reset.pc", pc, 64'h0);
        chk("reset.halted", 64'(halted), 64'h0);
        step("boot", 0,0,0,0,0,0,0,0, 26'h0, 19'h0, 64'h0, fv, tk);
        chk("boot.fetch_valid", 64'(fv), 64'h0);

        // Sequential fetch 0,4,8,C.
        for (int i = 0; i < 4; i++) begin
            step("seq", 0,0,0,0,0,0,0,0, 26'h0, 19'h0, 64'h0, fv, tk);
            chk("seq.fetch_valid", 64'(fv), 64'h1);
            chk("seq.pc_next", pc, 64'(4 * (i + 1)));
            chk("seq.direccion_next", 64'(direccion), 64'(i + 1));
        end

        // Backward B by two words from 0x10.
        step("b_back", 0,0,0,1,0,0,0,0, 26'h3FFFFFE, 19'h0, 64'h0, fv, tk);
        chk("b_back.taken", 64'(tk), 64'h1);
        chk("b_back.pc", pc, 64'h08);
        step("b_fwd", 0,0,0,1,0,0,0,0, 26'h6, 19'h0, 64'h0, fv, tk);
        chk("b_fwd.pc", pc, 64'h20);

        // CBZ at 0x20: not taken then taken.
        step("cbz_nt", 0,0,0,0,1,0,0,0, 26'h0, 19'h3, 64'h0, fv, tk);
        chk("cbz_nt.taken", 64'(tk), 64'h0);
        chk("cbz_nt.pc", pc, 64'h24);
        step("br_back", 0,0,0,0,0,0,1,0, 26'h0, 19'h0, 64'h20, fv, tk);
        chk("br_back.pc", pc, 64'h20);
        step("cbz_t", 0,0,0,0,1,0,0,1, 26'h0, 19'h3, 64'h0, fv, tk);
        chk("cbz_t.taken", 64'(tk), 64'h1);
        chk("cbz_t.pc", pc, 64'h2C);

        // Stall overrides a pending B for three cycles.
        for (int i = 0; i < 3; i++) begin
            step("stall", 0,1,0,1,0,0,0,0, 26'h1, 19'h0, 64'h0, fv, tk);
            chk("stall.fetch_valid", 64'(fv), 64'h0);
            chk("stall.taken", 64'(tk), 64'h0);
            chk("stall.pc", pc, 64'h2C);
        end

        // Fall off the end of a 128-byte memory.
        step("br_end", 0,0,0,0,0,0,1,0, 26'h0, 19'h0, 64'h7C, fv, tk);
        chk("br_end.pc", pc, 64'h7C);
        step("bound", 0,0,0,0,0,0,0,0, 26'h0, 19'h0, 64'h0, fv, tk);
        chk("bound.halted", 64'(halted), 64'h1);
        chk("bound.pc", pc, 64'h7C);
        step("frozen", 0,0,0,0,0,0,1,0, 26'h0, 19'h0, 64'h10, fv, tk);
        chk("frozen.pc", pc, 64'h7C);
        chk("frozen.fetch_valid", 64'(fv), 64'h0);

        step("reset2", 1,0,0,0,0,0,0,0, 26'h0, 19'h0, 64'h0, fv, tk);
        chk("reset2.pc", pc, 64'h0);
        chk("reset2.halted", 64'(halted), 64'h0);
        step("boot2", 0,0,0,0,0,0,0,0, 26'h0, 19'h0, 64'h0, fv, tk);

        // Misaligned BR target.
        step("br_mis", 0,0,0,0,0,0,1,0, 26'h0, 19'h0, 64'h42, fv, tk);
`ifdef PC_ALIGN_CHECK_EN
        chk("br_mis.halted", 64'(halted), 64'h1);
        chk("br_mis.fault", 64'(fault), 64'h1);
        chk("br_mis.pc", pc, 64'h0);
`else
        chk("br_mis.pc", pc, 64'h40);
        chk("br_mis.halted", 64'(halted), 64'h0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic        r_rs;
            logic [25:0] r26;
            logic [18:0] r19;
            r_rs = halted ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
            r26  = 26'($urandom_range(0, 16)) - 26'd8;
            r19  = 19'($urandom_range(0, 16)) - 19'd8;
            if ($urandom_range(0, 49) == 0) r26 = 26'h2000000;
            step("rand", r_rs, $urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 1'($urandom_range(0, 1)), r26, r19, 64'($urandom_range(0, 140)), fv, tk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
